data_mem_responder: RTL
=======================

Name: data_mem_responder

Overview:
- Multi-cycle data-memory slave answering load/store requests from the processor datapath; the responder end of the datapath's data-memory interface.
- Replaces a zero-latency memory with a valid/ready request and response handshake and programmable wait states, so stalling logic can be exercised.
- Holds a word-addressed internal array and flags misaligned or out-of-range accesses.

Parameters:
- ADDR_W, 32, request address width in bits.
- DATA_W, 32, data word width in bits.
- DEPTH_LOG2, 8, log2 of the number of words in the array (256 words).
- WAIT_CYCLES, 2, wait states between request acceptance and the response; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  requester has a request.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  DATA_W  load data; 0 for stores and errors.
- rsp_err  out  1  access was misaligned or out of range.

Behaviour:
- Reset, asynchronous, rst_n low:
  - state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch write, addr and wdata, and compute err.
  - Go to WAIT if WAIT_CYCLES > 0, else go to RESP.
- Error rule:
  - err = (addr[1:0] != 0) | (addr[ADDR_W-1:DEPTH_LOG2+2] != 0).
  - Word index = addr[DEPTH_LOG2+1:2].
- Store commit:
  - Happens on the acceptance edge, only if err = 0.
  - An erroring store leaves the array untouched.
- WAIT:
  - req_ready = 0.
  - Counter loads WAIT_CYCLES-1 on entry and decrements each cycle.
  - Move to RESP when the counter reaches 0.
- RESP entry:
  - rsp_valid = 1.
  - rsp_err = latched err.
  - rsp_rdata = array[index] for an error-free load, else 0.
- Latency: rsp_valid rises exactly WAIT_CYCLES+1 cycles after the acceptance edge.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err hold stable until rsp_valid & rsp_ready.
  - On that handshake: rsp_valid = 0, rsp_err = 0, rsp_rdata = 0, go to IDLE.
- No overlap between requests:
  - req_ready is high only in IDLE.
  - Maximum throughput is one access per WAIT_CYCLES+2 cycles.
- Requester inputs are ignored outside the IDLE acceptance cycle; latched values are used.
- Reset mid-operation:
  - Any pending response is dropped.
  - A store already accepted stays committed.
  - Return to IDLE.
- Store data is visible to a load accepted on the next request.

Optional Feature:
- Macro: DATA_MEM_RESPONDER_STATS_EN.
- When defined:
  - Adds output ports rd_count [15:0] and wr_count [15:0] and output err_count [7:0].
  - rd_count / wr_count count completed error-free loads / stores.
  - err_count counts error responses and saturates at 255.
  - All three increment on the response handshake edge.
  - rd_count and wr_count wrap modulo 2^16.
  - All reset to 0.
- When undefined: the ports and counters do not exist, and all other behaviour is identical.

Decomposition:
- Shared package data_mem_pkg:
  - FSM state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2).
  - Constants for default widths and depth.
  - A function computing the error flag from the address.
- One natural sub-module: data_mem_array, a synchronous-write, combinational-read word array with parameters DATA_W and DEPTH_LOG2.
- FSM and handshake logic stay in the top module.

Test Plan:
- Store/load round trip: store 0xDEADBEEF to 0x10, then load 0x10.
  - Load response has rsp_rdata = 0xDEADBEEF and rsp_err = 0.
  - rsp_valid rises exactly 3 cycles after acceptance (WAIT_CYCLES = 2).
- Misaligned store: store 0x12345678 to 0x13.
  - Store response has rsp_err = 1.
  - A following load of 0x10 still returns 0xDEADBEEF.
- Out of range: load 0x400 (DEPTH_LOG2 = 8).
  - Response has rsp_err = 1 and rsp_rdata = 0.
  - With stats enabled, err_count = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles during a load of 0x10.
  - rsp_valid stays 1, data 0xDEADBEEF stays stable, req_ready stays 0.
  - Response completes on the cycle rsp_ready rises.
- Reset mid-operation: assert rst_n = 0 in WAIT after accepting a load.
  - rsp_valid = 0 and req_ready = 1 immediately (asynchronous).
  - No response is issued after reset is released.
- Zero wait states (WAIT_CYCLES = 0): back-to-back loads with rsp_ready tied high.
  - rsp_valid is asserted 1 cycle after each acceptance.
  - Requests are accepted every 2 cycles.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data-memory responder: FSM state encoding,
// default geometry, and the misaligned/out-of-range address check.
package data_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_DATA_W     = 32;
    localparam int DEF_DEPTH_LOG2 = 8;

    // Address is zero-extended to 64 bits so one function serves any ADDR_W up to 64.
    function automatic logic addr_err(input logic [63:0] addr, input int addr_w,
                                      input int depth_log2);
        logic err;
        err = (addr[1:0] != 2'b00);
        for (int i = 0; i < 64; i++) begin
            if (i >= depth_log2 + 2 && i < addr_w) begin
                err = err | addr[i];
            end
        end
        return err;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word array with a synchronous write port and a combinational read port.
// Contents are deliberately not reset.
module data_mem_array #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_idx,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DEPTH_LOG2-1:0] rd_idx,
    output logic [DATA_W-1:0]     rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wdata;
        end
    end

    assign rdata = mem[rd_idx];

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave with valid/ready request and response handshakes
// and WAIT_CYCLES wait states. Optional counters: DATA_MEM_RESPONDER_STATS_EN.
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int DEPTH_LOG2  = DEF_DEPTH_LOG2,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
`ifdef DATA_MEM_RESPONDER_STATS_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count,
    output logic [7:0]        err_count
`endif
);

    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t                state, state_next;
    logic [3:0]            cnt;
    logic                  lat_write, lat_err;
    logic [DEPTH_LOG2-1:0] lat_idx;

    logic                  accept, handshake, enter_resp;
    logic                  req_err;
    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  sel_write, sel_err;
    logic [DEPTH_LOG2-1:0] sel_idx;
    logic [DATA_W-1:0]     rd_data;

    assign req_ready = (state == IDLE);
    assign accept    = req_ready & req_valid;
    assign handshake = rsp_valid & rsp_ready;
    assign req_err   = addr_err(64'(req_addr), ADDR_W, DEPTH_LOG2);
    assign req_idx   = req_addr[DEPTH_LOG2+1:2];

    // With zero wait states the response is built on the acceptance edge, so
    // the live request must be used instead of the not-yet-latched copy.
    assign sel_write = req_ready ? req_write : lat_write;
    assign sel_err   = req_ready ? req_err   : lat_err;
    assign sel_idx   = req_ready ? req_idx   : lat_idx;

    assign enter_resp = (state_next == RESP) && (state != RESP);

    data_mem_array #(
        .DATA_W    (DATA_W),
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk   (clk),
        .we    (accept & req_write & ~req_err),
        .wr_idx(req_idx),
        .wdata (req_wdata),
        .rd_idx(sel_idx),
        .rdata (rd_data)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
            WAIT:    if (cnt == 4'd0) state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (enter_resp) begin
                rsp_valid <= 1'b1;
                rsp_err   <= sel_err;
                rsp_rdata <= (sel_write | sel_err) ? '0 : rd_data;
            end else if (handshake) begin
                rsp_valid <= 1'b0;
                rsp_err   <= 1'b0;
                rsp_rdata <= '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_write <= req_write;
            lat_err   <= req_err;
            lat_idx   <= req_idx;
        end
    end

`ifdef DATA_MEM_RESPONDER_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count  <= 16'd0;
            wr_count  <= 16'd0;
            err_count <= 8'd0;
        end else if (handshake) begin
            if (lat_err) begin
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end else if (lat_write) begin
                wr_count <= wr_count + 16'd1;
            end else begin
                rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif

endmodule
